// File: rtl/draw_bg_rom_pkg.sv
// bg_pkg: shared constants and types for the scrolling background renderer.
//
// Contents
//   H_ACTIVE / V_ACTIVE : visible raster size in pixels
//   ROM_AW              : background ROM address width ({y[9:0], x[9:0]})
//   RGB_W               : pixel colour width ({r,g,b}, 4 bits each)
//   BG_LATENCY          : clock cycles from the VGA inputs to the outputs
//   AXIS_W              : width of one ROM address axis
//   timing_t            : the VGA timing bundle carried alongside the pixel
//   in_active()         : true when a counter pair lies inside the visible raster
package bg_pkg;

  localparam int H_ACTIVE   = 1024;
  localparam int V_ACTIVE   = 768;
  localparam int ROM_AW     = 20;
  localparam int RGB_W      = 12;
  localparam int BG_LATENCY = 3;
  localparam int AXIS_W     = 10;

  // Field order fixes the bit layout of the delay-line bus (26 bits).
  typedef struct packed {
    logic [10:0] hcount;
    logic [10:0] vcount;
    logic        hsync;
    logic        hblnk;
    logic        vsync;
    logic        vblnk;
  } timing_t;

  localparam int TIMING_W = $bits(timing_t);

  function automatic logic in_active(input logic [10:0] h, input logic [10:0] v);
    return (h < 11'(H_ACTIVE)) && (v < 11'(V_ACTIVE));
  endfunction

endpackage

// File: rtl/draw_bg_rom_sig_delay.sv
// sig_delay: fixed-depth shift register used to align a bus with a pipeline.
//
// Parameters
//   WIDTH : bus width in bits
//   DEPTH : number of register stages (>= 1); dout equals din DEPTH cycles ago
// Ports
//   clk  : clock
//   rst  : asynchronous active-high reset, clears every stage to 0
//   din  : bus entering the delay line
//   dout : bus leaving the delay line
module sig_delay #(
  parameter int WIDTH = 26,
  parameter int DEPTH = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  logic [WIDTH-1:0] pipe [DEPTH];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) pipe[i] <= '0;
    end else begin
      pipe[0] <= din;
      for (int i = 1; i < DEPTH; i++) pipe[i] <= pipe[i-1];
    end
  end

  assign dout = pipe[DEPTH-1];

endmodule

// File: rtl/draw_bg_rom.sv
// draw_bg_rom: paints a background image held in an external ROM onto the
// VGA raster, optionally scrolling it horizontally by SCROLL_STEP pixels on
// every frame.
//
// Build option
//   DRAW_BG_SCROLL_EN : when defined, a vsync rising-edge detector advances a
//                       10-bit horizontal offset once per frame. When
//                       undefined the offset is constant 0 and the x address
//                       is hcount_in[9:0]. Latency is the same in both builds.
//
// Pipeline (3 cycles, inputs -> outputs)
//   stage 1 : rom_address registered from the current counters
//   stage 2 : ROM returns rom_rgb (registered read inside the ROM)
//   stage 3 : rgb_out registered, forced to 0 off-screen or while blanking
//
// Ports
//   clk, rst                         : pixel clock, async active-high reset
//   hcount_in, vcount_in             : incoming VGA counters (11 bits)
//   hsync_in, hblnk_in, vsync_in,
//   vblnk_in                         : incoming VGA timing
//   rom_address                      : ROM address {y[9:0], x[9:0]}
//   rom_rgb                          : ROM data, valid one cycle after address
//   hcount_out .. vblnk_out          : timing delayed by 3 cycles
//   rgb_out                          : pixel colour {r,g,b}
//
// Handshake: none. The block is a free-running pipeline; every input cycle
// produces exactly one output cycle three clocks later.
import bg_pkg::*;

module draw_bg_rom #(
  parameter int SCROLL_STEP = 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [10:0]         hcount_in,
  input  logic [10:0]         vcount_in,
  input  logic                hsync_in,
  input  logic                hblnk_in,
  input  logic                vsync_in,
  input  logic                vblnk_in,
  output logic [ROM_AW-1:0]   rom_address,
  input  logic [RGB_W-1:0]    rom_rgb,
  output logic [10:0]         hcount_out,
  output logic [10:0]         vcount_out,
  output logic                hsync_out,
  output logic                hblnk_out,
  output logic                vsync_out,
  output logic                vblnk_out,
  output logic [RGB_W-1:0]    rgb_out
);

  // ---------------------------------------------------------------------
  // Horizontal scroll offset
  // ---------------------------------------------------------------------
  logic [AXIS_W-1:0] offset;

`ifdef DRAW_BG_SCROLL_EN
  logic vsync_prev;
  logic vsync_rise;

  assign vsync_rise = vsync_in & ~vsync_prev;

  // The offset moves only on the vsync edge, which sits in vertical
  // blanking, so a visible line is always addressed with one offset.
  // Addresses formed on the edge cycle still use the old value.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vsync_prev <= 1'b0;
      offset     <= '0;
    end else begin
      vsync_prev <= vsync_in;
      if (vsync_rise) offset <= offset + AXIS_W'(SCROLL_STEP);
    end
  end
`else
  // Scrolling compiled out: the step is masked away so the offset is the
  // constant 0 whatever SCROLL_STEP holds.
  assign offset = AXIS_W'(SCROLL_STEP) & '0;
`endif

  // ---------------------------------------------------------------------
  // Stage 1: address generation
  // ---------------------------------------------------------------------
  logic              on_screen;
  logic [AXIS_W-1:0] x_addr;

  assign on_screen = in_active(hcount_in, vcount_in);
  // 10-bit add; the carry out is dropped so the image wraps at 1024.
  assign x_addr    = hcount_in[AXIS_W-1:0] + offset;

  // pass_d* tracks whether the pixel travelling down the pipe may show ROM
  // data. Being 0 out of reset also keeps rgb_out black until the first
  // real pixel arrives, whatever the ROM output register holds.
  logic pass_d1;
  logic pass_d2;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rom_address <= '0;
      pass_d1     <= 1'b0;
    end else begin
      rom_address <= on_screen ? {vcount_in[AXIS_W-1:0], x_addr} : '0;
      pass_d1     <= on_screen & ~hblnk_in & ~vblnk_in;
    end
  end

  // ---------------------------------------------------------------------
  // Stage 2/3: wait for ROM data, then register the colour
  // ---------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pass_d2 <= 1'b0;
      rgb_out <= '0;
    end else begin
      pass_d2 <= pass_d1;
      rgb_out <= pass_d2 ? rom_rgb : '0;
    end
  end

  // ---------------------------------------------------------------------
  // Timing alignment
  // ---------------------------------------------------------------------
  timing_t timing_in;
  timing_t timing_out;

  assign timing_in = '{hcount: hcount_in, vcount: vcount_in,
                       hsync: hsync_in, hblnk: hblnk_in,
                       vsync: vsync_in, vblnk: vblnk_in};

  sig_delay #(
    .WIDTH (TIMING_W),
    .DEPTH (BG_LATENCY)
  ) u_timing_delay (
    .clk  (clk),
    .rst  (rst),
    .din  (timing_in),
    .dout (timing_out)
  );

  assign hcount_out = timing_out.hcount;
  assign vcount_out = timing_out.vcount;
  assign hsync_out  = timing_out.hsync;
  assign hblnk_out  = timing_out.hblnk;
  assign vsync_out  = timing_out.vsync;
  assign vblnk_out  = timing_out.vblnk;

endmodule

// File: tb/tb_draw_bg_rom.sv
// Testbench for draw_bg_rom. Two instances share the same VGA stimulus:
// dut_a with SCROLL_STEP=1 and dut_b with SCROLL_STEP=1000. Each has its own
// ROM model with a one-cycle registered read. A behavioural model derives the
// expected address and 3-cycle-delayed outputs from the input history and the
// count of vsync rising edges seen since reset.
module tb_draw_bg_rom;

`ifdef DRAW_BG_SCROLL_EN
  localparam bit SCROLL_ON = 1'b1;
`else
  localparam bit SCROLL_ON = 1'b0;
`endif

  localparam int STEP_A = 1;
  localparam int STEP_B = 1000;
  localparam int EXP_W  = 26 + 12 + 12;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  // ---------------- stimulus signals ----------------
  logic [10:0] hc = '0, vc = '0;
  logic        hs = 1'b0, hb = 1'b0, vs = 1'b0, vb = 1'b0;

  logic [19:0] addr_a, addr_b;
  logic [11:0] rom_a = '0, rom_b = '0;
  logic [11:0] rgb_a, rgb_b;
  logic [10:0] ho_a, vo_a, ho_b, vo_b;
  logic        hso_a, hbo_a, vso_a, vbo_a;
  logic        hso_b, hbo_b, vso_b, vbo_b;

  draw_bg_rom #(.SCROLL_STEP(STEP_A)) dut_a (
    .clk(clk), .rst(rst),
    .hcount_in(hc), .vcount_in(vc),
    .hsync_in(hs), .hblnk_in(hb), .vsync_in(vs), .vblnk_in(vb),
    .rom_address(addr_a), .rom_rgb(rom_a),
    .hcount_out(ho_a), .vcount_out(vo_a),
    .hsync_out(hso_a), .hblnk_out(hbo_a), .vsync_out(vso_a), .vblnk_out(vbo_a),
    .rgb_out(rgb_a)
  );

  draw_bg_rom #(.SCROLL_STEP(STEP_B)) dut_b (
    .clk(clk), .rst(rst),
    .hcount_in(hc), .vcount_in(vc),
    .hsync_in(hs), .hblnk_in(hb), .vsync_in(vs), .vblnk_in(vb),
    .rom_address(addr_b), .rom_rgb(rom_b),
    .hcount_out(ho_b), .vcount_out(vo_b),
    .hsync_out(hso_b), .hblnk_out(hbo_b), .vsync_out(vso_b), .vblnk_out(vbo_b),
    .rgb_out(rgb_b)
  );

  // ---------------- ROM models ----------------
  function automatic logic [11:0] rom_f(input logic [19:0] a);
    return a[11:0] ^ a[19:8] ^ 12'h5A3;
  endfunction

  always @(posedge clk) begin
    rom_a <= rom_f(addr_a);
    rom_b <= rom_f(addr_b);
  end

  // ---------------- behavioural model ----------------
  int          rises = 0;
  bit          m_prev_vs = 1'b0;
  logic [EXP_W-1:0] exp_q[$];

  function automatic int offset_of(input int step);
    return SCROLL_ON ? (rises * step) % 1024 : 0;
  endfunction

  function automatic logic [19:0] model_addr(input int h, input int v, input int off);
    if (h < 1024 && v < 768) return {10'(v), 10'((h + off) % 1024)};
    return '0;
  endfunction

  // ---------------- scoreboard ----------------
  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    exp_q.delete();
    exp_q.push_back('0);
    exp_q.push_back('0);
    rises = 0;
    m_prev_vs = 1'b0;
  endtask

  // One pixel clock: drive inputs, predict, clock, compare every output.
  task automatic cyc(input int h, input int v, input bit s_hs, input bit s_hb,
                     input bit s_vs, input bit s_vb);
    logic [19:0] ea, eb;
    logic [EXP_W-1:0] e;
    bit show;
    hc = 11'(h); vc = 11'(v); hs = s_hs; hb = s_hb; vs = s_vs; vb = s_vb;
    ea = model_addr(h, v, offset_of(STEP_A));
    eb = model_addr(h, v, offset_of(STEP_B));
    show = (h < 1024) && (v < 768) && !s_hb && !s_vb;
    exp_q.push_back({11'(h), 11'(v), s_hs, s_hb, s_vs, s_vb,
                     show ? rom_f(ea) : 12'h000, show ? rom_f(eb) : 12'h000});
    if (s_vs && !m_prev_vs) rises++;
    m_prev_vs = s_vs;
    @(posedge clk);
    #1;
    check("addr_a", addr_a, ea);
    check("addr_b", addr_b, eb);
    e = exp_q.pop_front();
    check("timing_a", {ho_a, vo_a, hso_a, hbo_a, vso_a, vbo_a}, e[49:24]);
    check("timing_b", {ho_b, vo_b, hso_b, hbo_b, vso_b, vbo_b}, e[49:24]);
    check("rgb_a", rgb_a, e[23:12]);
    check("rgb_b", rgb_b, e[11:0]);
    @(negedge clk);
  endtask

  // Asynchronous reset: outputs must clear before any clock edge.
  task automatic do_reset();
    rst = 1'b1;
    #1;
    check("rst_addr_a", addr_a, 0);
    check("rst_addr_b", addr_b, 0);
    check("rst_rgb_a", rgb_a, 0);
    check("rst_rgb_b", rgb_b, 0);
    check("rst_timing_a", {ho_a, vo_a, hso_a, hbo_a, vso_a, vbo_a}, 0);
    check("rst_timing_b", {ho_b, vo_b, hso_b, hbo_b, vso_b, vbo_b}, 0);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(0, 0, 0, 0, 0, 0);
  endtask

  task automatic vs_pulses(input int n);
    for (int i = 0; i < n; i++) begin
      cyc(0, 780, 0, 1, 1, 1);
      cyc(0, 780, 0, 1, 0, 1);
    end
  endtask

  // ---------------- main sequence ----------------
  initial begin
    #2;
    @(negedge clk);
    do_reset();

    // Basic address and 3-cycle colour latency.
    cyc(5, 7, 0, 0, 0, 0);
    check("lit_addr_5_7", addr_a, 20'h01C05);
    cyc(0, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0);
    check("lit_rgb_5_7", rgb_a, 12'h9BA);

    // Off-screen column.
    cyc(1030, 7, 0, 0, 0, 0);
    check("lit_addr_1030", addr_a, 0);
    idle(2);
    check("lit_rgb_1030", rgb_a, 0);

    // Three frames then the right-hand edge wraps.
    do_reset();
    vs_pulses(3);
    cyc(1023, 0, 0, 0, 0, 0);
    check("lit_wrap_a", addr_a[9:0], SCROLL_ON ? 2 : 1023);
    check("lit_wrap_b", addr_b[9:0], SCROLL_ON ? 951 : 1023);

    // Large step wraps the offset itself.
    do_reset();
    vs_pulses(2);
    cyc(0, 0, 0, 0, 0, 0);
    check("lit_step1000", addr_b[9:0], SCROLL_ON ? 976 : 0);

    // Fast toggling and a long high level: one step per rising edge.
    do_reset();
    for (int i = 0; i < 10; i++) begin
      cyc(0, 780, 0, 1, 1, 1);
      cyc(0, 780, 0, 1, 0, 1);
    end
    for (int i = 0; i < 100; i++) cyc(0, 780, 0, 1, 1, 1);
    cyc(0, 780, 0, 1, 0, 1);
    cyc(0, 0, 0, 0, 0, 0);
    check("lit_hold_a", addr_a[9:0], SCROLL_ON ? 11 : 0);
    check("lit_hold_b", addr_b[9:0], SCROLL_ON ? 760 : 0);

    // Randomized raster fragments and random pixels.
    for (int f = 0; f < 6; f++) begin
      int line = $urandom_range(0, 900);
      for (int x = 0; x < 120; x++) begin
        int h = $urandom_range(0, 15) == 0 ? $urandom_range(1000, 1343) : x * 9;
        cyc(h, line, h >= 1048 && h < 1184, h >= 1024, 0, line >= 768);
      end
      vs_pulses($urandom_range(1, 3));
    end
    for (int i = 0; i < 1500; i++) begin
      cyc($urandom_range(0, 2047), $urandom_range(0, 1023),
          $urandom_range(0, 1) == 1, $urandom_range(0, 7) == 0,
          $urandom_range(0, 9) == 0, $urandom_range(0, 7) == 0);
    end

    // Mid-line reset: outputs clear at once, first pixel back at +3.
    for (int x = 100; x < 110; x++) cyc(x, 300, 0, 0, 0, 0);
    do_reset();
    cyc(5, 7, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0);
    check("lit_post_rst_zero", rgb_a, 0);
    cyc(0, 0, 0, 0, 0, 0);
    check("lit_post_rst_rgb", rgb_a, 12'h9BA);
    idle(3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
